// File: rtl/fifo_port_arbiter.sv
// Write-side round-robin arbiter, read gating and flush sequencer in front of a shared FIFO.
// Two producers share the write port, one consumer owns the read port, and per-producer counters record full-refusals.
module fifo_port_arbiter #(
  parameter int WL    = 3,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req0,
  input  logic [WL-1:0] din0,
  input  logic          req1,
  input  logic [WL-1:0] din1,
  input  logic          rdReq,
  input  logic          flush,
  input  logic          full,
  input  logic          empty,
  output logic          wReq,
  output logic [WL-1:0] din,
  output logic          rReq,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rdGnt,
  output logic          flushBusy,
  output logic [CW-1:0] deny0,
  output logic [CW-1:0] deny1
);

  typedef enum logic {NORMAL, FLUSH} state_t;

  localparam logic [CW-1:0] DENY_MAX = '1;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] deny0_q, deny0_d;
  logic [CW-1:0] deny1_q, deny1_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= NORMAL;
      prio_q  <= 1'b0;
      deny0_q <= '0;
      deny1_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      deny0_q <= deny0_d;
      deny1_q <= deny1_d;
    end
  end

  // Outputs are held inactive while RST is high so the FIFO sees no request during reset.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    deny0_d   = deny0_q;
    deny1_d   = deny1_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    wReq      = 1'b0;
    din       = '0;
    rReq      = 1'b0;
    rdGnt     = 1'b0;
    flushBusy = 1'b0;
    if (!RST) begin
      unique case (state_q)
        NORMAL: begin
          if (!full) begin
            if (req0 && req1) begin
              gnt0 = ~prio_q;
              gnt1 = prio_q;
            end else begin
              gnt0 = req0;
              gnt1 = req1;
            end
          end
          wReq  = gnt0 | gnt1;
          din   = gnt1 ? din1 : din0;
          rdGnt = rdReq & ~empty;
          rReq  = rdGnt;
          if (gnt0) begin
            prio_d = 1'b1;
          end else if (gnt1) begin
            prio_d = 1'b0;
          end
          // Only full-refusals count; losing arbitration is not a denial.
          if (full) begin
            if (req0 && deny0_q != DENY_MAX) deny0_d = deny0_q + 1'b1;
            if (req1 && deny1_q != DENY_MAX) deny1_d = deny1_q + 1'b1;
          end
          if (flush) state_d = FLUSH;
        end
        FLUSH: begin
          flushBusy = 1'b1;
          rReq      = ~empty;
          if (empty) state_d = NORMAL;
        end
        default: state_d = NORMAL;
      endcase
    end
  end

  assign deny0 = deny0_q;
  assign deny1 = deny1_q;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter: FIFO flags are driven by hand and every expected value is hand-computed.
// A second instance with 2-bit deny counters covers saturation.
module tb_fifo_port_arbiter;

  localparam int WL = 3;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          rst_sat;
  logic          req0, req1, rd_req, flush, full, empty;
  logic [WL-1:0] din0, din1;

  logic          w_req, r_req, gnt0, gnt1, rd_gnt, flush_busy;
  logic [WL-1:0] din;
  logic [CW-1:0] deny0, deny1;

  logic          s_w_req, s_r_req, s_gnt0, s_gnt1, s_rd_gnt, s_flush_busy;
  logic [WL-1:0] s_din;
  logic [1:0]    s_deny0, s_deny1;

  int total = 0;
  int bad   = 0;

  fifo_port_arbiter #(.WL(WL), .DEPTH(4), .CW(CW)) dut (
    .CLK(clk), .RST(rst), .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .rdReq(rd_req), .flush(flush), .full(full), .empty(empty),
    .wReq(w_req), .din(din), .rReq(r_req), .gnt0(gnt0), .gnt1(gnt1),
    .rdGnt(rd_gnt), .flushBusy(flush_busy), .deny0(deny0), .deny1(deny1)
  );

  fifo_port_arbiter #(.WL(WL), .DEPTH(4), .CW(2)) dut_sat (
    .CLK(clk), .RST(rst_sat), .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .rdReq(rd_req), .flush(flush), .full(full), .empty(empty),
    .wReq(s_w_req), .din(s_din), .rReq(s_r_req), .gnt0(s_gnt0), .gnt1(s_gnt1),
    .rdGnt(s_rd_gnt), .flushBusy(s_flush_busy), .deny0(s_deny0), .deny1(s_deny1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic apply_stimulus(input logic r0, input logic [WL-1:0] d0,
                                input logic r1, input logic [WL-1:0] d1,
                                input logic rd, input logic fl,
                                input logic fu, input logic em);
    @(negedge clk);
    req0 = r0; din0 = d0; req1 = r1; din1 = d1;
    rd_req = rd; flush = fl; full = fu; empty = em;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [WL-1:0] seq_din [4];
    logic [1:0]    sat_exp [5];
    seq_din = '{3'd2, 3'd5, 3'd7, 3'd4};
    sat_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    rst = 1'b1; rst_sat = 1'b1;
    req0 = 0; req1 = 0; rd_req = 0; flush = 0; full = 0; empty = 1; din0 = 0; din1 = 0;

    // Outputs forced inactive during reset even with live requests.
    apply_stimulus(1, 3'd5, 1, 3'd6, 1, 0, 0, 0);
    check_output("rst_wReq", w_req, 0);
    check_output("rst_gnt0", gnt0, 0);
    check_output("rst_rReq", r_req, 0);
    check_output("rst_din", din, 0);
    check_output("rst_deny0", deny0, 0);
    check_output("rst_flushBusy", flush_busy, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;

    // Single producer fills the FIFO, then is refused while full.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, seq_din[i], 0, 0, 0, 0, 0, (i == 0));
      check_output("single_gnt0", gnt0, 1);
      check_output("single_wReq", w_req, 1);
      check_output("single_din", din, seq_din[i]);
    end
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1, 3'd1, 0, 0, 0, 0, 1, 0);
      check_output("full_gnt0", gnt0, 0);
      check_output("full_wReq", w_req, 0);
      check_output("full_deny0", deny0, k);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0);
    check_output("full_deny0_final", deny0, 3);

    // Lone producer 1 grant hands priority back to producer 0.
    apply_stimulus(0, 0, 1, 3'd3, 0, 0, 0, 0);
    check_output("p1_gnt1", gnt1, 1);
    check_output("p1_din", din, 3);

    // Contention alternates starting with producer 0.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 3'd1, 1, 3'd6, 0, 0, 0, 0);
      check_output("rr_gnt0", gnt0, (i % 2 == 0));
      check_output("rr_gnt1", gnt1, (i % 2 == 1));
      check_output("rr_din", din, (i % 2 == 0) ? 1 : 6);
    end

    // Read gating and simultaneous read/write.
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 1);
    check_output("rd_empty_rdGnt", rd_gnt, 0);
    check_output("rd_empty_rReq", r_req, 0);
    apply_stimulus(1, 3'd2, 0, 0, 1, 0, 0, 0);
    check_output("rw_wReq", w_req, 1);
    check_output("rw_rReq", r_req, 1);
    check_output("rw_rdGnt", rd_gnt, 1);
    apply_stimulus(1, 3'd2, 0, 0, 1, 0, 1, 0);
    check_output("rw_full_wReq", w_req, 0);
    check_output("rw_full_rReq", r_req, 1);
    check_output("rw_full_deny0", deny0, 3);

    // Flush a full FIFO; the sampling cycle is still NORMAL and counts one refusal.
    apply_stimulus(0, 0, 1, 3'd5, 0, 1, 1, 0);
    check_output("fl_pulse_busy", flush_busy, 0);
    check_output("fl_pulse_gnt1", gnt1, 0);
    check_output("fl_pulse_deny0", deny0, 4);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 1, 3'd5, 1, 0, (i == 0), 0);
      check_output("fl_busy", flush_busy, 1);
      check_output("fl_rReq", r_req, 1);
      check_output("fl_gnt1", gnt1, 0);
      check_output("fl_rdGnt", rd_gnt, 0);
      check_output("fl_deny1", deny1, 1);
    end
    apply_stimulus(0, 0, 1, 3'd5, 0, 0, 0, 1);
    check_output("fl_empty_busy", flush_busy, 1);
    check_output("fl_empty_rReq", r_req, 0);
    apply_stimulus(0, 0, 1, 3'd5, 0, 0, 0, 1);
    check_output("fl_done_busy", flush_busy, 0);
    check_output("fl_done_gnt1", gnt1, 1);
    check_output("fl_done_din", din, 5);
    check_output("fl_done_deny1", deny1, 1);

    // Flushing an empty FIFO lasts one cycle.
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 1);
    check_output("fe_pulse_busy", flush_busy, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    check_output("fe_busy", flush_busy, 1);
    check_output("fe_rReq", r_req, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    check_output("fe_done_busy", flush_busy, 0);

    // 2-bit deny counter saturates at 3.
    rst_sat = 1'b0;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1, 0, 0, 0, 0, 0, 1, 0);
      check_output("sat_deny0", s_deny0, sat_exp[k]);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0);
    check_output("sat_deny0_final", s_deny0, 3);
    check_output("main_deny0_after_sat", deny0, 9);

    // Grant producer 0 so priority points at producer 1 before the reset.
    apply_stimulus(1, 3'd4, 0, 0, 0, 0, 0, 0);
    check_output("pre_rst_gnt0", gnt0, 1);

    // Reset in the middle of a flush.
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("mfr_busy_before", flush_busy, 1);
    rst = 1'b1;
    #1;
    check_output("mfr_busy", flush_busy, 0);
    check_output("mfr_rReq", r_req, 0);
    check_output("mfr_deny0", deny0, 0);
    check_output("mfr_deny1", deny1, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    apply_stimulus(1, 3'd1, 1, 3'd6, 0, 0, 0, 1);
    check_output("mfr_prio_gnt0", gnt0, 1);
    check_output("mfr_prio_gnt1", gnt1, 0);
    check_output("mfr_state_busy", flush_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_port_arbiter.md
Name: fifo_port_arbiter

Overview:
- Front-end controller for the shared FIFO. Two producers share the FIFO write port under round-robin arbitration, and one consumer uses the read port.
- Write grants are gated by FIFO full and read grants by FIFO empty, so the FIFO never sees an illegal request and its error flag never asserts.
- A flush FSM drains the FIFO on command.
- Per-producer saturating counters record write attempts refused because the FIFO was full.

Parameters:
- WL, 3, data word width; must match the FIFO's WL.
- DEPTH, 4, FIFO depth. Informational only, used by the bench; the block relies on the FIFO's full/empty flags.
- CW, 8, width of each deny counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- req0  input  1  producer 0 write request.
- din0  input  WL  producer 0 write data.
- req1  input  1  producer 1 write request.
- din1  input  WL  producer 1 write data.
- rdReq  input  1  consumer read request.
- flush  input  1  drain command; sampled as a level in NORMAL.
- full  input  1  FIFO full flag.
- empty  input  1  FIFO empty flag.
- wReq  output  1  FIFO write request.
- din  output  WL  FIFO write data.
- rReq  output  1  FIFO read request.
- gnt0  output  1  producer 0 write accepted this cycle.
- gnt1  output  1  producer 1 write accepted this cycle.
- rdGnt  output  1  consumer read accepted this cycle; the FIFO's dout is the consumer's data.
- flushBusy  output  1  high while in FLUSH.
- deny0  output  CW  count of producer 0 full-refusals.
- deny1  output  CW  count of producer 1 full-refusals.

Behaviour:
- Registered state:
  - state in {NORMAL, FLUSH}.
  - prio: 0 means producer 0 wins contention.
  - deny0, deny1.
- Reset (async, RST high): state=NORMAL, prio=0, deny0=deny1=0. While RST is high, wReq, rReq, gnt0, gnt1, rdGnt and flushBusy are forced 0 and din=0.
- All grants and FIFO requests are combinational in the same cycle. The FIFO acts on the following rising edge, so request-to-FIFO-write latency is 0 cycles.
- NORMAL, write side:
  - If full=1: gnt0=gnt1=0.
  - Else if exactly one producer requests: that producer is granted.
  - Else if both request: the producer selected by prio is granted.
  - wReq = gnt0 | gnt1.
  - din = din1 if gnt1, otherwise din0.
- NORMAL, prio update: at each edge where a grant occurs, prio <= index of the producer not granted. With no grant, prio holds.
- NORMAL, deny counters: at each edge where full=1, each producer with its req high increments its deny counter, saturating at 2^CW-1. Arbitration losses are not counted.
- NORMAL, read side: rdGnt = rReq = rdReq & ~empty.
- Simultaneous read and write are allowed in the same cycle, including when full=1 (write still blocked) or empty=1 (read blocked).
- NORMAL to FLUSH: flush=1 at an edge moves state to FLUSH. Arbitration in the cycle flush is sampled proceeds normally.
- FLUSH:
  - gnt0=gnt1=wReq=rdGnt=0.
  - rReq = ~empty; read data is discarded.
  - flushBusy=1.
  - req0, req1, rdReq and flush are ignored; no deny counting and no prio change.
- FLUSH to NORMAL: at the first edge where empty=1. Flushing an already-empty FIFO therefore lasts exactly one cycle with rReq=0.
- Reset mid-flush aborts immediately to NORMAL with all counters cleared.
- Deny counters never wrap.

Test Plan:
- Reset then single producer:
  - Stimulus: RST 1 to 0; req0=1 with din0=2,5,7,4 on consecutive cycles.
  - Required: gnt0 and wReq high for 4 cycles and din follows 2,5,7,4. After full=1, gnt0=0, and deny0 counts 1,2,3 over the next 3 held cycles.
- Contention round-robin:
  - Stimulus: empty FIFO, req0=req1=1 for 4 cycles, din0=1, din1=6.
  - Required: grants alternate gnt0,gnt1,gnt0,gnt1 and din=1,6,1,6. prio reads 1,0,1,0 after each edge.
- Read gating and simultaneous read/write:
  - Stimulus: rdReq=1 with the FIFO empty.
  - Required: rdGnt=0 and rReq=0.
  - Stimulus: FIFO holding 2 words, req0=1, rdReq=1.
  - Required: wReq=1 and rReq=1 in the same cycle; FIFO error stays 0.
- Flush:
  - Stimulus: FIFO full with 4 words, pulse flush for 1 cycle while req1=1.
  - Required: flushBusy=1 and rReq=1 for 4 cycles, gnt1=0 and deny1 unchanged. Return to NORMAL one edge after empty=1, then gnt1=1.
  - Stimulus: flush on an empty FIFO.
  - Required: exactly one flushBusy cycle with rReq=0.
- Saturation and mid-flush reset:
  - Stimulus: CW=2, full=1, req0=1 for 5 cycles.
  - Required: deny0 reads 1,2,3,3,3.
  - Stimulus: assert RST during FLUSH.
  - Required: flushBusy drops immediately, deny0=0 and prio=0.
